// File: rtl/corepll_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package corepll_pkg;

  localparam int CNT_W = 20;

  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 1000000;
  localparam int DEF_STABLE_CYC       = 1024;
  localparam int DEF_MAX_RETRIES      = 3;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level, cleared by async reset.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock, then releases
// the core; retries on lock timeout and parks in FAIL after MAX_RETRIES.
module pll_reset_ctrl
  import corepll_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int STABLE_CYC       = DEF_STABLE_CYC,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       clr_stats,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] loss_count
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);

  logic             locked_s;
  pll_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       retries, retries_n;
  logic [7:0]       loss_n;

  bit_sync u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Next state and counters; outputs are decoded from state_n at the register.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    retries_n = retries;
    loss_n    = loss_count;

    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          retries_n = retries + 8'd1;
          state_n   = (retries_n == RETRY_LIMIT) ? FAIL : PLL_RST;
          cnt_n     = '0;
        end
      end
      STABLE: begin
        // A drop during qualification is a glitch, not a loss.
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n   = RUN;
          retries_n = '0;
          cnt_n     = '0;
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!locked_s) begin
          state_n = PLL_RST;
          if (loss_count != 8'hFF) loss_n = loss_count + 8'd1;
        end
      end
      FAIL: begin
        cnt_n = '0;
        if (retry_req) begin
          state_n   = PLL_RST;
          retries_n = '0;
        end
      end
      default: begin
        state_n = PLL_RST;
        cnt_n   = '0;
      end
    endcase

    if (clr_stats) loss_n = '0;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= PLL_RST;
      cnt        <= '0;
      retries    <= '0;
      loss_count <= '0;
      pll_rst    <= 1'b1;
      core_rst   <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retries    <= retries_n;
      loss_count <= loss_n;
      pll_rst    <= (state_n == PLL_RST);
      core_rst   <= (state_n != RUN);
      ready      <= (state_n == RUN);
      fail       <= (state_n == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed scenarios with literal expectations plus
// randomized lock/pulse stimulus compared every cycle to a phase/age model.
module tb_pll_reset_ctrl;

  localparam int RP = 4;
  localparam int TO = 32;
  localparam int ST = 8;
  localparam int MR = 3;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       clr_stats = 1'b0;
  logic       retry_req = 1'b0;
  logic       pll_rst, core_rst, ready, fail;
  logic [7:0] loss_count;

  int checks = 0;
  int passed = 0;
  bit started = 1'b0;

  pll_reset_ctrl #(
    .RST_PULSE_CYC    (RP),
    .LOCK_TIMEOUT_CYC (TO),
    .STABLE_CYC       (ST),
    .MAX_RETRIES      (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .clr_stats  (clr_stats),
    .retry_req  (retry_req),
    .pll_rst    (pll_rst),
    .core_rst   (core_rst),
    .ready      (ready),
    .fail       (fail),
    .loss_count (loss_count)
  );

  always #5 refclk = ~refclk;

  // Behavioural model: a phase, how many edges have elapsed in it, the
  // number of consecutive timeouts, and the loss tally. The lock input is
  // seen by the decision logic two edges after it is sampled.
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
  int ph, age, tmo, losses;
  bit lk_ago1, lk_ago2, lk_seen;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      ph = P_RST; age = 0; tmo = 0; losses = 0;
      lk_ago1 = 1'b0; lk_ago2 = 1'b0;
    end else begin
      lk_seen = lk_ago2;
      lk_ago2 = lk_ago1;
      lk_ago1 = locked;
      age++;
      case (ph)
        P_RST:  if (age == RP) begin ph = P_WAIT; age = 0; end
        P_WAIT: begin
          if (lk_seen) begin ph = P_STAB; age = 0; end
          else if (age == TO) begin
            tmo++;
            ph  = (tmo == MR) ? P_FAIL : P_RST;
            age = 0;
          end
        end
        P_STAB: begin
          if (!lk_seen) begin ph = P_WAIT; age = 0; end
          else if (age == ST) begin ph = P_RUN; age = 0; tmo = 0; end
        end
        P_RUN: begin
          if (!lk_seen) begin
            if (losses < 255) losses++;
            ph = P_RST; age = 0;
          end
        end
        default: if (retry_req) begin ph = P_RST; age = 0; tmo = 0; end
      endcase
      if (clr_stats) losses = 0;
    end
  end

  logic [11:0] act_v, exp_v;
  always @(posedge refclk) begin
    #2;
    if (started) begin
      exp_v = {ph == P_RST, ph != P_RUN, ph == P_RUN, ph == P_FAIL, 8'(losses)};
      act_v = {pll_rst, core_rst, ready, fail, loss_count};
      checks++;
      if (act_v === exp_v) passed++;
      else $display("FAIL model_cmp t=%0t {pll_rst,core_rst,ready,fail,loss}: got %h, expected %h",
                    $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_ready(input string name, input int max);
    int n;
    n = 0;
    while (!ready && n < max) begin
      @(negedge refclk);
      n++;
    end
    chk(name, int'(ready), 1);
  endtask

  // One-cycle lock drop seen in RUN; optionally clear stats on the edge that counts it.
  task automatic do_loss(input bit clr);
    locked = 1'b0;
    @(negedge refclk);
    locked = 1'b1;
    @(negedge refclk);
    clr_stats = clr;
    @(negedge refclk);
    clr_stats = 1'b0;
    wait_ready("loss_relock", 60);
  endtask

  task automatic pulse_reset(input bit lk);
    @(negedge refclk);
    rst = 1'b1;
    locked = lk;
    repeat (2) @(negedge refclk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, pulses;
    bit prev;

    repeat (3) @(negedge refclk);
    started = 1'b1;
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_core_rst", int'(core_rst), 1);
    chk("reset_ready", int'(ready), 0);
    chk("reset_fail", int'(fail), 0);
    chk("reset_loss", int'(loss_count), 0);

    // Nominal lock: locked rises 10 cycles after release.
    rst = 1'b0;
    #1;
    n = pll_rst ? 1 : 0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge refclk);
      if (k <= 9 && pll_rst) n++;
      if (k == 10) begin
        chk("nominal_pulse_len", n, RP);
        locked = 1'b1;
      end
      if (k == 20) chk("nominal_not_yet_run", int'(ready), 0);
      if (k == 21) begin
        chk("nominal_ready", int'(ready), 1);
        chk("nominal_core_rst", int'(core_rst), 0);
      end
    end

    // Single-cycle lock loss in RUN.
    locked = 1'b0;
    @(negedge refclk);
    locked = 1'b1;
    chk("loss_sync_lat1", int'(ready), 1);
    @(negedge refclk);
    chk("loss_sync_lat2", int'(pll_rst), 0);
    @(negedge refclk);
    chk("loss_pll_rst", int'(pll_rst), 1);
    chk("loss_core_rst", int'(core_rst), 1);
    chk("loss_count1", int'(loss_count), 1);
    wait_ready("loss_rerun", 60);
    chk("loss_count1_kept", int'(loss_count), 1);

    // Saturation: 255 more losses, then a clear coinciding with an increment.
    for (int i = 0; i < 255; i++) do_loss(1'b0);
    chk("loss_saturated", int'(loss_count), 255);
    do_loss(1'b1);
    chk("loss_clear_wins", int'(loss_count), 0);

    // Glitch during STABLE, locked held through reset.
    pulse_reset(1'b1);
    for (int k = 1; k <= 22; k++) begin
      @(negedge refclk);
      if (k == 8) locked = 1'b0;
      if (k == 11) locked = 1'b1;
      if (k == 13) chk("glitch_delays_run", int'(ready), 0);
      if (k == 21) chk("glitch_not_yet_run", int'(ready), 0);
      if (k == 22) begin
        chk("glitch_run", int'(ready), 1);
        chk("glitch_loss", int'(loss_count), 0);
      end
    end

    // Timeouts into FAIL, with a stray retry_req in WAIT_LOCK.
    pulse_reset(1'b0);
    pulses = 1;
    prev   = 1'b1;
    for (int k = 1; k <= 108; k++) begin
      @(negedge refclk);
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
      if (k == 50) retry_req = 1'b1;
      if (k == 51) retry_req = 1'b0;
      if (k == 107) chk("timeout_fail_early", int'(fail), 0);
      if (k == 108) begin
        chk("timeout_fail", int'(fail), 1);
        chk("timeout_pulses", pulses, MR);
        chk("fail_pll_rst", int'(pll_rst), 0);
        chk("fail_core_rst", int'(core_rst), 1);
      end
    end
    retry_req = 1'b1;
    @(negedge refclk);
    retry_req = 1'b0;
    chk("retry_pll_rst", int'(pll_rst), 1);
    chk("retry_fail_clr", int'(fail), 0);

    // Asynchronous reset between edges while in RUN.
    locked = 1'b1;
    wait_ready("arst_reach_run", 60);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_core_rst", int'(core_rst), 1);
    chk("arst_pll_rst", int'(pll_rst), 1);
    chk("arst_ready", int'(ready), 0);
    @(negedge refclk);
    rst = 1'b0;
    #1;
    n = pll_rst ? 1 : 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge refclk);
      if (pll_rst) n++;
    end
    chk("arst_restart_pulse", n, RP);

    // Randomized lock behaviour, stat clears, retries and occasional resets.
    begin
      int hold;
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge refclk);
        if (hold == 0) begin
          locked = ($urandom_range(0, 99) < 75);
          hold   = $urandom_range(1, 50);
        end
        hold--;
        retry_req = ($urandom_range(0, 29) == 0);
        clr_stats = ($urandom_range(0, 79) == 0);
        rst       = ($urandom_range(0, 999) == 0);
      end
      @(negedge refclk);
      rst = 1'b0;
      retry_req = 1'b0;
      clr_stats = 1'b0;
      repeat (3) @(negedge refclk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
